// File: rtl/aud_i2s_master_tx.sv
// Clock-master I2S transmitter: derives BCLK/LRCK from i_clk and serialises 16-bit stereo pairs, MSB first.
// Build option AUD_I2S_TX_UNDERRUN_HOLD_EN: on underrun, repeat the previous pair instead of sending silence.
module aud_i2s_master_tx #(
    parameter int CLK_DIV   = 2,
    parameter int SLOT_BITS = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_data_l,
    input  logic [15:0] i_data_r,
    input  logic        i_valid,
    output logic        o_ready,
    output logic        o_bclk,
    output logic        o_lrck,
    output logic        o_dat,
    output logic        o_frame_start,
    output logic        o_underrun
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SLOT_W = $clog2(2 * SLOT_BITS);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * SLOT_BITS - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(SLOT_BITS);
    localparam logic [SLOT_W-1:0] POS_ONE   = SLOT_W'(1);
    localparam logic [SLOT_W-1:0] POS_LAST  = SLOT_W'(16);

    logic [DIV_W-1:0]  div_q, div_d;
    logic              bclk_q, bclk_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              lrck_q, lrck_d;
    logic              dat_q, dat_d;
    logic [31:0]       shift_q, shift_d;
    logic [31:0]       hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic              ready_q, ready_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;

    logic              fall_s;
    logic              accept_s;
    logic              load_s;
    logic [SLOT_W-1:0] slot_next_s;
    logic              lrck_next_s;
    logic [SLOT_W-1:0] pos_s;
    logic [4:0]        bit_idx_s;

    // Next-state logic: divider, slot sequencing, serial bit select, frame load and handshake.
    always_comb begin
        div_d         = div_q;
        bclk_d        = bclk_q;
        slot_d        = slot_q;
        lrck_d        = lrck_q;
        dat_d         = dat_q;
        shift_d       = shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        frame_start_d = 1'b0;
        underrun_d    = 1'b0;

        fall_s      = (div_q == DIV_LAST) && bclk_q;
        accept_s    = i_valid && !hold_full_q;
        slot_next_s = (slot_q == SLOT_LAST) ? {SLOT_W{1'b0}} : slot_q + POS_ONE;
        load_s      = fall_s && (slot_next_s == {SLOT_W{1'b0}});
        lrck_next_s = (slot_next_s >= SLOT_HALF);
        pos_s       = lrck_next_s ? slot_next_s - SLOT_HALF : slot_next_s;
        // Left word sits in shift[31:16], right in shift[15:0]; p=1 selects the MSB.
        bit_idx_s   = (lrck_next_s ? 5'd16 : 5'd0) - pos_s[4:0];

        if (div_q == DIV_LAST) begin
            div_d  = {DIV_W{1'b0}};
            bclk_d = !bclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end

        if (fall_s) begin
            slot_d = slot_next_s;
            lrck_d = lrck_next_s;
            if ((pos_s >= POS_ONE) && (pos_s <= POS_LAST)) begin
                dat_d = shift_q[bit_idx_s];
            end else begin
                dat_d = 1'b0;
            end
        end else begin
            dat_d = dat_q;
        end

        if (load_s) begin
            frame_start_d = 1'b1;
            hold_full_d   = 1'b0;
            if (accept_s) begin
                shift_d = {i_data_l, i_data_r};
            end else if (hold_full_q) begin
                shift_d = hold_q;
            end else begin
                underrun_d = 1'b1;
`ifdef AUD_I2S_TX_UNDERRUN_HOLD_EN
                shift_d = shift_q;
`else
                shift_d = 32'h0000_0000;
`endif
            end
        end else if (accept_s) begin
            hold_d      = {i_data_l, i_data_r};
            hold_full_d = 1'b1;
        end else begin
            hold_full_d = hold_full_q;
        end

        ready_d = !hold_full_d;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            div_q         <= {DIV_W{1'b0}};
            bclk_q        <= 1'b0;
            slot_q        <= SLOT_LAST;
            lrck_q        <= 1'b1;
            dat_q         <= 1'b0;
            shift_q       <= 32'h0000_0000;
            hold_q        <= 32'h0000_0000;
            hold_full_q   <= 1'b0;
            ready_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            div_q         <= div_d;
            bclk_q        <= bclk_d;
            slot_q        <= slot_d;
            lrck_q        <= lrck_d;
            dat_q         <= dat_d;
            shift_q       <= shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            ready_q       <= ready_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_bclk        = bclk_q;
    assign o_lrck        = lrck_q;
    assign o_dat         = dat_q;
    assign o_frame_start = frame_start_q;
    assign o_underrun    = underrun_q;

endmodule
